udp_payload_pingpong: RTL and testbench
=======================================

Name: udp_payload_pingpong

Overview:
- Upstream payload stage for the UDP frame generator.
- Collects payload bytes from the data source, such as the acquisition/sample path, into two ping-pong banks of exactly PAYLOAD_LEN bytes each.
- When the generator reaches its payload phase, the block streams one complete bank back-to-back, one byte per clk.
- Single clock domain. Overflow is detected and counted, never silently absorbed.

Parameters:
- PAYLOAD_LEN, 1040: bytes per frame payload (per bank); legal range 2..1472.
- ADDR_W, 11: bank address width; must satisfy 2^ADDR_W >= PAYLOAD_LEN.

Ports:
- clk  in  1  system/byte clock
- rst_n  in  1  reset, asynchronous, active-low
- i_wr_en  in  1  write strobe, one payload byte
- i_wr_data  in  8  payload byte
- o_wr_ready  out  1  current write bank can accept a byte
- i_rd_start  in  1  pulse: begin streaming the oldest full bank
- o_rd_data  out  8  payload byte to generator
- o_rd_valid  out  1  o_rd_data valid
- o_rd_last  out  1  final byte of bank (coincident with o_rd_valid)
- o_frame_avail  out  1  a full bank is waiting and the reader is idle
- o_len  out  16  constant PAYLOAD_LEN (feeds IP/UDP length fields)
- o_ovf  out  1  sticky: a byte was dropped
- o_drop_cnt  out  16  dropped-byte count, saturates at 16'hFFFF
- i_ovf_clr  in  1  clears o_ovf and o_drop_cnt

Behaviour:
- Reset (async): both banks EMPTY; wr_bank=0, wr_addr=0; rd_bank=0; read FSM RD_IDLE. All outputs 0 except o_len=PAYLOAD_LEN and o_wr_ready=1. A frame in progress is discarded.
- Per-bank state: EMPTY, FILLING, FULL, READING (registered).
- o_wr_ready is combinational: 1 when bank[wr_bank] is EMPTY or FILLING.
- Write path (i_wr_en & o_wr_ready):
  - Store the byte at bank[wr_bank][wr_addr].
  - If wr_addr == PAYLOAD_LEN-1: bank goes FULL, wr_bank toggles, wr_addr=0.
  - Otherwise: wr_addr++, bank goes FILLING.
- Dropped write (i_wr_en & !o_wr_ready): byte discarded, o_ovf<=1, o_drop_cnt saturating increment.
- Clear priority: i_ovf_clr wins over a same-cycle drop; the result is ovf=0, cnt=0.
- o_frame_avail = (bank[rd_bank]==FULL) & (FSM==RD_IDLE).
- Read FSM:
  - RD_IDLE -> RD_RUN on i_rd_start & o_frame_avail; bank[rd_bank] goes READING and rd_addr=0.
  - i_rd_start is ignored otherwise, including while in RD_RUN.
  - RAM read is synchronous, 1-cycle latency.
  - If i_rd_start is sampled at edge N, o_rd_valid is high from the cycle after edge N+1 for exactly PAYLOAD_LEN consecutive cycles, with no gaps. Bytes are presented in write order.
  - o_rd_last is high with the PAYLOAD_LEN-th byte.
  - At the edge ending the last byte: o_rd_valid=0, bank goes EMPTY, rd_bank toggles, FSM returns to RD_IDLE.
  - o_frame_avail may reassert on the next cycle if the other bank is FULL.
- o_rd_data holds its last value when not valid (don't-care for the consumer).
- Simultaneous events:
  - Final write to one bank and final read of the other in the same cycle: both take effect.
  - A write targeting a bank that is READING is dropped, even in its freeing cycle. The freed bank accepts writes from the next cycle.
  - Write and read of different banks never interact. A write and a read of the same bank are impossible by state.
- Ordering: banks are consumed strictly in fill order (rd_bank/wr_bank alternate).
- Arithmetic: addresses compare against PAYLOAD_LEN-1 at ADDR_W bits; no wrap beyond PAYLOAD_LEN.

Test Plan:
- PAYLOAD_LEN=18. Write 0x00..0x11 continuously -> o_frame_avail=1 on the cycle after the 18th write. i_rd_start -> 18 valid cycles starting 2 cycles later, data 0x00..0x11, o_rd_last on 0x11, then o_frame_avail=0.
- Write 36 bytes (0..35) with no reads -> o_wr_ready=0 after byte 35. Write 3 more -> o_ovf=1, o_drop_cnt=3. i_ovf_clr -> both 0.
- Two full banks, read both back-to-back (i_rd_start again on the first idle cycle) -> bytes 0..17 then 18..35, o_rd_last twice, no reordering.
- Final write of bank1 in the same cycle as o_rd_last of bank0 -> bank1 FULL, bank0 EMPTY, o_frame_avail=1 next cycle, o_wr_ready=1 (bank0).
- i_rd_start with no full bank, and a second i_rd_start pulse mid-stream -> ignored; valid count stays exactly 18.
- Assert rst_n=0 mid-read (byte 7) -> o_rd_valid=0 immediately. After release: o_frame_avail=0, o_wr_ready=1, o_drop_cnt=0.

Source files
------------

// File: rtl/udp_payload_pingpong.sv
// Ping-pong payload buffer feeding the UDP frame generator.
// Two banks of PAYLOAD_LEN bytes each. Bytes from the data source fill one bank
// while the other bank is streamed out, one byte per clock, when the generator
// asks for a payload. Writes that find no free bank are dropped and counted.
module udp_payload_pingpong #(
  parameter int PAYLOAD_LEN = 1040,
  parameter int ADDR_W      = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_wr_en,
  input  logic [7:0]  i_wr_data,
  output logic        o_wr_ready,
  input  logic        i_rd_start,
  output logic [7:0]  o_rd_data,
  output logic        o_rd_valid,
  output logic        o_rd_last,
  output logic        o_frame_avail,
  output logic [15:0] o_len,
  output logic        o_ovf,
  output logic [15:0] o_drop_cnt,
  input  logic        i_ovf_clr
);

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_READING
  } bank_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_RUN
  } rd_state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PAYLOAD_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam int                MEM_DEPTH = 2 ** (ADDR_W + 1);

  // Both banks share one array; the bank index is the address MSB.
  logic [7:0]        mem [0:MEM_DEPTH-1];

  bank_state_t       bank_st [2];
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_bank;
  logic [ADDR_W-1:0] rd_addr;
  rd_state_t         rd_state;
  rd_state_t         rd_state_next;

  logic              wr_accept;
  logic              wr_drop;
  logic              wr_at_end;
  logic              rd_accept;
  logic              rd_issue;
  logic              rd_done;

  assign o_len         = 16'(PAYLOAD_LEN);
  assign o_wr_ready    = (bank_st[wr_bank] == BANK_EMPTY) || (bank_st[wr_bank] == BANK_FILLING);
  assign wr_accept     = i_wr_en & o_wr_ready;
  assign wr_drop       = i_wr_en & ~o_wr_ready;
  assign wr_at_end     = (wr_addr == LAST_ADDR);
  assign o_frame_avail = (bank_st[rd_bank] == BANK_FULL) && (rd_state == RD_IDLE);

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= RD_IDLE;
    end else begin
      rd_state <= rd_state_next;
    end
  end

  // Read FSM next state: issue one RAM read per cycle until the last byte is
  // on the output, then spend that byte's cycle retiring the bank.
  always_comb begin
    rd_state_next = rd_state;
    rd_accept     = 1'b0;
    rd_issue      = 1'b0;
    rd_done       = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (i_rd_start && o_frame_avail) begin
          rd_accept     = 1'b1;
          rd_state_next = RD_RUN;
        end
      end
      RD_RUN: begin
        if (o_rd_last) begin
          rd_done       = 1'b1;
          rd_state_next = RD_IDLE;
        end else begin
          rd_issue = 1'b1;
        end
      end
      default: rd_state_next = RD_IDLE;
    endcase
  end

  // Payload storage write port (no reset: contents are don't-care until written).
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[{wr_bank, wr_addr}] <= i_wr_data;
    end
  end

  // Write pointer: advance within the bank, hop to the other bank after the last byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      wr_addr <= '0;
    end else if (wr_accept) begin
      if (wr_at_end) begin
        wr_addr <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_addr <= wr_addr + ADDR_ONE;
      end
    end
  end

  // Per-bank ownership. Reader and writer never address the same bank in one
  // cycle, so the two update paths below never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st[0] <= BANK_EMPTY;
      bank_st[1] <= BANK_EMPTY;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (rd_accept && (rd_bank == 1'(b))) begin
          bank_st[b] <= BANK_READING;
        end else if (rd_done && (rd_bank == 1'(b))) begin
          bank_st[b] <= BANK_EMPTY;
        end else if (wr_accept && (wr_bank == 1'(b))) begin
          bank_st[b] <= wr_at_end ? BANK_FULL : BANK_FILLING;
        end
      end
    end
  end

  // Read datapath: registered RAM read gives valid one cycle after the address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank    <= 1'b0;
      rd_addr    <= '0;
      o_rd_data  <= 8'h00;
      o_rd_valid <= 1'b0;
      o_rd_last  <= 1'b0;
    end else if (rd_accept) begin
      rd_addr <= '0;
    end else if (rd_issue) begin
      o_rd_data  <= mem[{rd_bank, rd_addr}];
      o_rd_valid <= 1'b1;
      o_rd_last  <= (rd_addr == LAST_ADDR);
      if (rd_addr != LAST_ADDR) begin
        rd_addr <= rd_addr + ADDR_ONE;
      end
    end else if (rd_done) begin
      o_rd_valid <= 1'b0;
      o_rd_last  <= 1'b0;
      rd_bank    <= ~rd_bank;
    end
  end

  // Overflow tracking: a clear in the same cycle as a drop leaves both at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ovf      <= 1'b0;
      o_drop_cnt <= 16'h0000;
    end else if (i_ovf_clr) begin
      o_ovf      <= 1'b0;
      o_drop_cnt <= 16'h0000;
    end else if (wr_drop) begin
      o_ovf <= 1'b1;
      if (o_drop_cnt != 16'hFFFF) begin
        o_drop_cnt <= o_drop_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_udp_payload_pingpong.sv
// Directed bench for udp_payload_pingpong with an 18-byte payload.
module tb_udp_payload_pingpong;

  localparam int LEN = 18;

  logic        clk;
  logic        rst_n;
  logic        i_wr_en;
  logic [7:0]  i_wr_data;
  logic        o_wr_ready;
  logic        i_rd_start;
  logic [7:0]  o_rd_data;
  logic        o_rd_valid;
  logic        o_rd_last;
  logic        o_frame_avail;
  logic [15:0] o_len;
  logic        o_ovf;
  logic [15:0] o_drop_cnt;
  logic        i_ovf_clr;

  int checks   = 0;
  int failures = 0;

  udp_payload_pingpong #(.PAYLOAD_LEN(LEN), .ADDR_W(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_wr_en       (i_wr_en),
    .i_wr_data     (i_wr_data),
    .o_wr_ready    (o_wr_ready),
    .i_rd_start    (i_rd_start),
    .o_rd_data     (o_rd_data),
    .o_rd_valid    (o_rd_valid),
    .o_rd_last     (o_rd_last),
    .o_frame_avail (o_frame_avail),
    .o_len         (o_len),
    .o_ovf         (o_ovf),
    .o_drop_cnt    (o_drop_cnt),
    .i_ovf_clr     (i_ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        rd_start;
    logic        ovf_clr;
    logic        e_ready;
    logic        e_valid;
    logic [7:0]  e_data;
    logic        e_last;
    logic        e_avail;
    logic        e_ovf;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: inputs already set, outputs sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    i_wr_en    = 1'b0;
    i_wr_data  = 8'h00;
    i_rd_start = 1'b0;
    i_ovf_clr  = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic wr_bytes(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      i_wr_en   = 1'b1;
      i_wr_data = 8'(base + i);
      cyc();
    end
    i_wr_en = 1'b0;
  endtask

  // Bounded wait for the last byte of a stream to appear on the outputs.
  task automatic wait_last(input string nm);
    int c;
    c = 0;
    while (!o_rd_last && c < 40) begin
      cyc();
      c++;
    end
    chk(nm, int'(o_rd_last), 1);
  endtask

  task automatic add_vec(input logic wr_en, input int wr_data, input logic rd_start,
                         input logic e_ready, input logic e_valid, input int e_data,
                         input logic e_last, input logic e_avail);
    vec_t v;
    v.wr_en    = wr_en;
    v.wr_data  = 8'(wr_data);
    v.rd_start = rd_start;
    v.ovf_clr  = 1'b0;
    v.e_ready  = e_ready;
    v.e_valid  = e_valid;
    v.e_data   = 8'(e_data);
    v.e_last   = e_last;
    v.e_avail  = e_avail;
    v.e_ovf    = 1'b0;
    v.e_cnt    = 16'h0000;
    vecs.push_back(v);
  endtask

  initial begin
    int idx;
    int lasts;
    int starts;
    int vcount;

    // Table: start with no full bank, fill bank0, stream it with a stray
    // start pulse mid-stream, then confirm the stream stops after LEN bytes.
    add_vec(1'b0, 0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int k = 0; k < LEN; k++)
      add_vec(1'b1, k, 1'b0, 1'b1, 1'b0, 0, 1'b0, k == LEN - 1);
    add_vec(1'b0, 0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int j = 0; j < LEN; j++)
      add_vec(1'b0, 0, j == 5, 1'b1, 1'b1, j, j == LEN - 1, 1'b0);
    add_vec(1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    add_vec(1'b0, 0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    add_vec(1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);

    do_reset();
    chk("reset_len", int'(o_len), LEN);
    chk("reset_wr_ready", int'(o_wr_ready), 1);
    chk("reset_rd_valid", int'(o_rd_valid), 0);
    chk("reset_rd_last", int'(o_rd_last), 0);
    chk("reset_rd_data", int'(o_rd_data), 0);
    chk("reset_avail", int'(o_frame_avail), 0);
    chk("reset_ovf", int'(o_ovf), 0);
    chk("reset_drop_cnt", int'(o_drop_cnt), 0);

    for (int n = 0; n < vecs.size(); n++) begin
      i_wr_en    = vecs[n].wr_en;
      i_wr_data  = vecs[n].wr_data;
      i_rd_start = vecs[n].rd_start;
      i_ovf_clr  = vecs[n].ovf_clr;
      cyc();
      $display("vec %0d: wr=%0b/%02h start=%0b -> ready=%0b valid=%0b data=%02h last=%0b avail=%0b",
               n, vecs[n].wr_en, vecs[n].wr_data, vecs[n].rd_start,
               o_wr_ready, o_rd_valid, o_rd_data, o_rd_last, o_frame_avail);
      chk($sformatf("vec%0d_ready", n), int'(o_wr_ready), int'(vecs[n].e_ready));
      chk($sformatf("vec%0d_valid", n), int'(o_rd_valid), int'(vecs[n].e_valid));
      chk($sformatf("vec%0d_last", n), int'(o_rd_last), int'(vecs[n].e_last));
      chk($sformatf("vec%0d_avail", n), int'(o_frame_avail), int'(vecs[n].e_avail));
      chk($sformatf("vec%0d_ovf", n), int'(o_ovf), int'(vecs[n].e_ovf));
      chk($sformatf("vec%0d_cnt", n), int'(o_drop_cnt), int'(vecs[n].e_cnt));
      if (vecs[n].e_valid)
        chk($sformatf("vec%0d_data", n), int'(o_rd_data), int'(vecs[n].e_data));
    end
    i_rd_start = 1'b0;

    // Overflow: fill both banks, then drop bytes; clear beats a same-cycle drop.
    do_reset();
    wr_bytes(2 * LEN - 1, 0);
    chk("ovf_ready_before_last", int'(o_wr_ready), 1);
    wr_bytes(1, 2 * LEN - 1);
    chk("ovf_ready_after_35", int'(o_wr_ready), 0);
    chk("ovf_avail_after_35", int'(o_frame_avail), 1);
    wr_bytes(1, 8'hE0);
    chk("ovf_flag_1", int'(o_ovf), 1);
    chk("ovf_cnt_1", int'(o_drop_cnt), 1);
    wr_bytes(2, 8'hE1);
    $display("overflow: ovf=%0b drop_cnt=%0d", o_ovf, o_drop_cnt);
    chk("ovf_flag_3", int'(o_ovf), 1);
    chk("ovf_cnt_3", int'(o_drop_cnt), 3);
    i_ovf_clr = 1'b1;
    cyc();
    i_ovf_clr = 1'b0;
    chk("clr_flag", int'(o_ovf), 0);
    chk("clr_cnt", int'(o_drop_cnt), 0);
    wr_bytes(2, 8'hE3);
    chk("redrop_cnt", int'(o_drop_cnt), 2);
    i_ovf_clr = 1'b1;
    i_wr_en   = 1'b1;
    cyc();
    i_ovf_clr = 1'b0;
    i_wr_en   = 1'b0;
    chk("clr_vs_drop_flag", int'(o_ovf), 0);
    chk("clr_vs_drop_cnt", int'(o_drop_cnt), 0);

    // Back-to-back read of both banks (still holding 0..35), restart on first idle cycle.
    i_rd_start = 1'b1;
    cyc();
    i_rd_start = 1'b0;
    starts = 1;
    idx    = 0;
    lasts  = 0;
    for (int c = 0; c < 60; c++) begin
      if (o_rd_valid) begin
        chk($sformatf("b2b_data%0d", idx), int'(o_rd_data), idx);
        chk($sformatf("b2b_last%0d", idx), int'(o_rd_last), int'(idx == LEN - 1 || idx == 2 * LEN - 1));
        if (o_rd_last) lasts++;
        idx++;
      end
      i_rd_start = (starts < 2) && o_frame_avail;
      if (i_rd_start) starts++;
      cyc();
    end
    i_rd_start = 1'b0;
    $display("back-to-back: bytes=%0d lasts=%0d", idx, lasts);
    chk("b2b_count", idx, 2 * LEN);
    chk("b2b_lasts", lasts, 2);
    chk("b2b_ready_after", int'(o_wr_ready), 1);
    chk("b2b_avail_after", int'(o_frame_avail), 0);

    // Final write of bank1 coincides with the last byte of bank0.
    do_reset();
    wr_bytes(LEN, 0);
    wr_bytes(LEN - 1, 100);
    i_rd_start = 1'b1;
    cyc();
    i_rd_start = 1'b0;
    wait_last("coinc_saw_last");
    i_wr_en   = 1'b1;
    i_wr_data = 8'(100 + LEN - 1);
    cyc();
    i_wr_en = 1'b0;
    $display("coincident: valid=%0b avail=%0b ready=%0b", o_rd_valid, o_frame_avail, o_wr_ready);
    chk("coinc_valid", int'(o_rd_valid), 0);
    chk("coinc_avail", int'(o_frame_avail), 1);
    chk("coinc_ready", int'(o_wr_ready), 1);
    chk("coinc_ovf", int'(o_ovf), 0);
    i_rd_start = 1'b1;
    cyc();
    i_rd_start = 1'b0;
    vcount = 0;
    for (int c = 0; c < 24; c++) begin
      if (o_rd_valid) begin
        chk($sformatf("coinc_bank1_data%0d", vcount), int'(o_rd_data), 100 + vcount);
        vcount++;
      end
      cyc();
    end
    chk("coinc_bank1_count", vcount, LEN);

    // Write aimed at a bank in its freeing cycle is dropped; bank accepts next cycle.
    do_reset();
    wr_bytes(2 * LEN, 0);
    i_rd_start = 1'b1;
    cyc();
    i_rd_start = 1'b0;
    wait_last("free_saw_last");
    i_wr_en   = 1'b1;
    i_wr_data = 8'hAA;
    cyc();
    i_wr_en = 1'b0;
    chk("free_drop_ovf", int'(o_ovf), 1);
    chk("free_drop_cnt", int'(o_drop_cnt), 1);
    chk("free_ready_next", int'(o_wr_ready), 1);
    wr_bytes(1, 8'hBB);
    chk("free_accept_cnt", int'(o_drop_cnt), 1);

    // Asynchronous reset in the middle of a stream.
    do_reset();
    wr_bytes(2 * LEN, 0);
    wr_bytes(2, 8'hF0);
    chk("pre_rst_cnt", int'(o_drop_cnt), 2);
    i_rd_start = 1'b1;
    cyc();
    i_rd_start = 1'b0;
    idx = 0;
    while (!(o_rd_valid && o_rd_data == 8'd7) && idx < 30) begin
      cyc();
      idx++;
    end
    chk("midrst_saw_byte7", int'(o_rd_valid && o_rd_data == 8'd7), 1);
    rst_n = 1'b0;
    #1;
    $display("mid-read reset: valid=%0b last=%0b", o_rd_valid, o_rd_last);
    chk("midrst_valid_now", int'(o_rd_valid), 0);
    chk("midrst_last_now", int'(o_rd_last), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("midrst_avail", int'(o_frame_avail), 0);
    chk("midrst_ready", int'(o_wr_ready), 1);
    chk("midrst_cnt", int'(o_drop_cnt), 0);
    chk("midrst_ovf", int'(o_ovf), 0);
    chk("midrst_len", int'(o_len), LEN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
